rr_stream_mux: RTL

//   Registered N-to-1 stream multiplexer with a valid/ready handshake on every channel and a W-bit data path.

---
 rtl/rr_stream_mux.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rr_stream_mux.sv
// Registered N-to-1 valid/ready stream mux with round-robin or fixed-select arbitration.
// Define MUX_LOCK_EN to add in_last/out_last and hold the grant until a packet's last beat.
module rr_stream_mux #(
    parameter int unsigned N = 9,
    parameter int unsigned W = 4,
    parameter int unsigned M = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
`ifdef MUX_LOCK_EN
    input  logic [N-1:0]   in_last,
    output logic           out_last,
`endif
    input  logic           mode,
    input  logic [M-1:0]   sel,
    output logic [W-1:0]   out_data,
    output logic [M-1:0]   out_chan,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [M-1:0] ptr_q;
    logic [W-1:0] data_q;
    logic [M-1:0] chan_q;
    logic         valid_q;

    logic         can_load;
    logic         gnt_valid;
    logic [M-1:0] gnt_idx;
    logic [W-1:0] gnt_data;
    logic         take;
    logic         ptr_adv;
    logic [M-1:0] ptr_next;
    logic [N-1:0] hi_req;
    logic [N-1:0] pick;

`ifdef MUX_LOCK_EN
    logic         lock_q;
    logic [M-1:0] lock_chan_q;
    logic         last_q;
    logic         gnt_last;
`endif

    assign can_load = !valid_q || out_ready;
    assign take     = rst_n && can_load && gnt_valid;
    assign ptr_next = (gnt_idx == M'(N - 1)) ? '0 : gnt_idx + 1'b1;

    // Arbitration: lock (if enabled) overrides mode; RR prefers requests at or above ptr.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        hi_req    = '0;
        pick      = '0;
`ifdef MUX_LOCK_EN
        if (lock_q) begin
            for (int i = 0; i < int'(N); i++) begin
                if (M'(i) == lock_chan_q && in_valid[i]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = M'(i);
                end
            end
        end else
`endif
        if (mode) begin
            for (int i = 0; i < int'(N); i++) begin
                if (M'(i) == sel && in_valid[i]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = M'(i);
                end
            end
        end else begin
            for (int i = 0; i < int'(N); i++) begin
                hi_req[i] = in_valid[i] && (M'(i) >= ptr_q);
            end
            pick = (|hi_req) ? hi_req : in_valid;
            for (int i = int'(N) - 1; i >= 0; i--) begin
                if (pick[i]) begin
                    gnt_valid = 1'b1;
                    gnt_idx   = M'(i);
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        gnt_data = '0;
`ifdef MUX_LOCK_EN
        gnt_last = 1'b0;
`endif
        for (int i = 0; i < int'(N); i++) begin
            if (M'(i) == gnt_idx) begin
                gnt_data = in_data[i*W +: W];
`ifdef MUX_LOCK_EN
                gnt_last = in_last[i];
`endif
            end
            in_ready[i] = take && (M'(i) == gnt_idx);
        end
`ifdef MUX_LOCK_EN
        // Only the packet-ending beat moves the pointer, so a locked packet keeps its slot.
        ptr_adv = gnt_last && (lock_q || !mode);
`else
        ptr_adv = !mode;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            data_q  <= '0;
            chan_q  <= '0;
            valid_q <= 1'b0;
`ifdef MUX_LOCK_EN
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
            last_q      <= 1'b0;
`endif
        end else if (can_load) begin
            if (gnt_valid) begin
                data_q  <= gnt_data;
                chan_q  <= gnt_idx;
                valid_q <= 1'b1;
                if (ptr_adv) begin
                    ptr_q <= ptr_next;
                end
`ifdef MUX_LOCK_EN
                last_q      <= gnt_last;
                lock_q      <= !gnt_last;
                lock_chan_q <= gnt_idx;
`endif
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign out_data  = data_q;
    assign out_chan  = chan_q;
    assign out_valid = valid_q;
`ifdef MUX_LOCK_EN
    assign out_last  = last_q;
`endif

endmodule
